// File: rtl/tlu_emulator.sv
// tlu_emulator
// Stands in for the TLU end of the RJ45 trigger/busy/clock link so the trigger
// path of tlu_controller can be looped back on the bench or on hardware. It
// issues periodic or software triggers and completes one of three protocols:
// simple, handshake, or data handshake. In data-handshake mode the trigger
// number is shifted out LSB first.
//
// Ports
//   BUS_CLK         single clock, all logic on the rising edge
//   BUS_RST         synchronous active-high reset
//   ENABLE          runs the period counter and allows triggers to start
//   MODE[1:0]       00 simple, 01 handshake, 10 data handshake, 11 as 00
//   PERIOD[15:0]    cycles between trigger starts (0 = periodic off)
//   SOFT_TRIG       one-cycle request for a single trigger (seen in IDLE only)
//   CLEAR_CNT       clears TRIGGER_NUMBER/ERR_CNT and pulses TLU_RESET
//   TLU_BUSY        asynchronous busy from the DUT
//   TLU_CLOCK       asynchronous serial clock from the DUT
//   TLU_TRIGGER     trigger / serial data line to the DUT
//   TLU_RESET       one-cycle pulse following CLEAR_CNT
//   TRIGGER_NUMBER  number of the next trigger to be sent
//   ERR_CNT[7:0]    saturating count of protocol timeouts
//   IDLE_OUT        high while the FSM sits in IDLE
//
// Build option TLU_EMU_VETO_EN adds input VETO and output VETO_CNT[15:0]: a
// start condition seen while VETO is high is discarded and counted instead.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a pending periodic request or SOFT_TRIG
// PULSE      | simple mode, TLU_TRIGGER held for PULSE_LEN cycles
// WAIT_BUSY  | TLU_TRIGGER held until the DUT raises BUSY
// SHIFT      | trigger number driven one bit per TLU_CLOCK rising edge
// WAIT_IDLE  | waiting for the DUT to drop BUSY
// HOLDOFF    | one cycle, advances TRIGGER_NUMBER
module tlu_emulator #(
  parameter int TRIGGER_BITS = 15,
  parameter int PULSE_LEN    = 4,
  parameter int TIMEOUT      = 1000
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic                    ENABLE,
  input  logic [1:0]              MODE,
  input  logic [15:0]             PERIOD,
  input  logic                    SOFT_TRIG,
  input  logic                    CLEAR_CNT,
  input  logic                    TLU_BUSY,
  input  logic                    TLU_CLOCK,
`ifdef TLU_EMU_VETO_EN
  input  logic                    VETO,
  output logic [15:0]             VETO_CNT,
`endif
  output logic                    TLU_TRIGGER,
  output logic                    TLU_RESET,
  output logic [TRIGGER_BITS-1:0] TRIGGER_NUMBER,
  output logic [7:0]              ERR_CNT,
  output logic                    IDLE_OUT
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PULSE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_HOLDOFF   = 3'd5;

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int PL_W = $clog2(PULSE_LEN + 1);
  localparam int BI_W = $clog2(TRIGGER_BITS + 1);

  localparam logic [TO_W-1:0] TO_LOAD    = TO_W'(TIMEOUT - 1);
  localparam logic [PL_W-1:0] PULSE_LOAD = PL_W'(PULSE_LEN - 1);
  localparam logic [BI_W-1:0] BIT_LAST   = BI_W'(TRIGGER_BITS);

  logic [2:0]              state, state_nxt;
  logic                    trig_nxt;
  logic [PL_W-1:0]         pulse_cnt, pulse_nxt;
  logic [TO_W-1:0]         to_cnt, to_nxt;
  logic [BI_W-1:0]         bit_idx, bit_nxt;
  logic                    data_mode, data_mode_nxt;
  logic [TRIGGER_BITS-1:0] num_nxt;
  logic [TRIGGER_BITS-1:0] num_shift;
  logic [7:0]              err_nxt;
  logic                    timeout;

  logic                    busy_s1, busy_s2;
  logic                    clk_s1, clk_s2, clk_s3;
  logic                    clk_rise;

  logic [15:0]             per_cnt;
  logic                    per_wrap;
  logic                    pending;
  logic                    start_req;
  logic                    start_go;

  assign clk_rise  = clk_s2 & ~clk_s3;
  assign num_shift = TRIGGER_NUMBER >> bit_idx;
  assign per_wrap  = ENABLE && (PERIOD != 16'd0) && (per_cnt >= PERIOD - 16'd1);
  assign start_req = (state == ST_IDLE) && ENABLE && (pending || SOFT_TRIG);

`ifdef TLU_EMU_VETO_EN
  assign start_go = start_req & ~VETO;
`else
  assign start_go = start_req;
`endif

  always_comb begin
    state_nxt     = state;
    trig_nxt      = TLU_TRIGGER;
    pulse_nxt     = pulse_cnt;
    to_nxt        = to_cnt;
    bit_nxt       = bit_idx;
    data_mode_nxt = data_mode;
    num_nxt       = TRIGGER_NUMBER;
    err_nxt       = ERR_CNT;
    timeout       = 1'b0;

    case (state)
      ST_IDLE: begin
        trig_nxt = 1'b0;
        if (start_go) begin
          trig_nxt  = 1'b1;
          pulse_nxt = PULSE_LOAD;
          to_nxt    = TO_LOAD;
          bit_nxt   = '0;
          case (MODE)
            2'b01: begin
              state_nxt     = ST_WAIT_BUSY;
              data_mode_nxt = 1'b0;
            end
            2'b10: begin
              state_nxt     = ST_WAIT_BUSY;
              data_mode_nxt = 1'b1;
            end
            default: state_nxt = ST_PULSE;
          endcase
        end
      end

      ST_PULSE: begin
        if (pulse_cnt == '0) begin
          trig_nxt  = 1'b0;
          state_nxt = ST_HOLDOFF;
        end else begin
          pulse_nxt = pulse_cnt - PL_W'(1);
        end
      end

      ST_WAIT_BUSY: begin
        if (busy_s2) begin
          trig_nxt  = 1'b0;
          to_nxt    = TO_LOAD;
          bit_nxt   = '0;
          state_nxt = data_mode ? ST_SHIFT : ST_WAIT_IDLE;
        end else if (to_cnt == '0) begin
          timeout = 1'b1;
        end else begin
          to_nxt = to_cnt - TO_W'(1);
        end
      end

      ST_SHIFT: begin
        // The last bit stays on the line for one cycle after its edge, then
        // the line returns low for the remainder of the transfer.
        if (bit_idx == BIT_LAST) begin
          trig_nxt  = 1'b0;
          to_nxt    = TO_LOAD;
          state_nxt = ST_WAIT_IDLE;
        end else if (clk_rise) begin
          trig_nxt = num_shift[0];
          bit_nxt  = bit_idx + BI_W'(1);
          to_nxt   = TO_LOAD;
        end else if (to_cnt == '0) begin
          timeout = 1'b1;
        end else begin
          to_nxt = to_cnt - TO_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        trig_nxt = 1'b0;
        if (!busy_s2) begin
          state_nxt = ST_HOLDOFF;
        end else if (to_cnt == '0) begin
          timeout = 1'b1;
        end else begin
          to_nxt = to_cnt - TO_W'(1);
        end
      end

      ST_HOLDOFF: begin
        trig_nxt  = 1'b0;
        num_nxt   = TRIGGER_NUMBER + 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        trig_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase

    if (timeout) begin
      trig_nxt  = 1'b0;
      state_nxt = ST_IDLE;
      if (ERR_CNT != 8'hFF) begin
        err_nxt = ERR_CNT + 8'd1;
      end
    end

    // Clearing overrides any increment landing in the same cycle.
    if (CLEAR_CNT) begin
      num_nxt = '0;
      err_nxt = '0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      busy_s1        <= 1'b0;
      busy_s2        <= 1'b0;
      clk_s1         <= 1'b0;
      clk_s2         <= 1'b0;
      clk_s3         <= 1'b0;
      state          <= ST_IDLE;
      TLU_TRIGGER    <= 1'b0;
      TLU_RESET      <= 1'b0;
      TRIGGER_NUMBER <= '0;
      ERR_CNT        <= '0;
      IDLE_OUT       <= 1'b0;
      pulse_cnt      <= '0;
      to_cnt         <= '0;
      bit_idx        <= '0;
      data_mode      <= 1'b0;
      per_cnt        <= '0;
      pending        <= 1'b0;
    end else begin
      busy_s1        <= TLU_BUSY;
      busy_s2        <= busy_s1;
      clk_s1         <= TLU_CLOCK;
      clk_s2         <= clk_s1;
      clk_s3         <= clk_s2;
      state          <= state_nxt;
      TLU_TRIGGER    <= trig_nxt;
      TLU_RESET      <= CLEAR_CNT;
      TRIGGER_NUMBER <= num_nxt;
      ERR_CNT        <= err_nxt;
      // Registered from the next state so it reads 0 during reset, as all
      // outputs do, and tracks the state register afterwards.
      IDLE_OUT       <= (state_nxt == ST_IDLE);
      pulse_cnt      <= pulse_nxt;
      to_cnt         <= to_nxt;
      bit_idx        <= bit_nxt;
      data_mode      <= data_mode_nxt;

      if (ENABLE && (PERIOD != 16'd0)) begin
        per_cnt <= per_wrap ? 16'd0 : per_cnt + 16'd1;
      end else begin
        per_cnt <= 16'd0;
      end

      // At most one request is held; a new wrap beats consumption.
      if (!ENABLE) begin
        pending <= 1'b0;
      end else if (per_wrap) begin
        pending <= 1'b1;
      end else if (start_req) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef TLU_EMU_VETO_EN
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      VETO_CNT <= 16'd0;
    end else if (CLEAR_CNT) begin
      VETO_CNT <= 16'd0;
    end else if (start_req && VETO && (VETO_CNT != 16'hFFFF)) begin
      VETO_CNT <= VETO_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator. The trigger number is 8 bits wide here so
// the wrap and the data-handshake pattern 0xA5 can be reached in a few
// thousand cycles; PULSE_LEN and TIMEOUT keep their default values.
module tb_tlu_emulator;

  localparam int TB_BITS = 8;

  logic               BUS_CLK = 1'b0;
  logic               BUS_RST = 1'b1;
  logic               ENABLE = 1'b0;
  logic [1:0]         MODE = 2'b00;
  logic [15:0]        PERIOD = 16'd0;
  logic               SOFT_TRIG = 1'b0;
  logic               CLEAR_CNT = 1'b0;
  logic               TLU_BUSY = 1'b0;
  logic               TLU_CLOCK = 1'b0;
  logic               TLU_TRIGGER;
  logic               TLU_RESET;
  logic [TB_BITS-1:0] TRIGGER_NUMBER;
  logic [7:0]         ERR_CNT;
  logic               IDLE_OUT;
`ifdef TLU_EMU_VETO_EN
  logic               VETO = 1'b0;
  logic [15:0]        VETO_CNT;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  tlu_emulator #(.TRIGGER_BITS(TB_BITS), .PULSE_LEN(4), .TIMEOUT(1000)) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST       (BUS_RST),
    .ENABLE        (ENABLE),
    .MODE          (MODE),
    .PERIOD        (PERIOD),
    .SOFT_TRIG     (SOFT_TRIG),
    .CLEAR_CNT     (CLEAR_CNT),
    .TLU_BUSY      (TLU_BUSY),
    .TLU_CLOCK     (TLU_CLOCK),
`ifdef TLU_EMU_VETO_EN
    .VETO          (VETO),
    .VETO_CNT      (VETO_CNT),
`endif
    .TLU_TRIGGER   (TLU_TRIGGER),
    .TLU_RESET     (TLU_RESET),
    .TRIGGER_NUMBER(TRIGGER_NUMBER),
    .ERR_CNT       (ERR_CNT),
    .IDLE_OUT      (IDLE_OUT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge BUS_CLK);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (IDLE_OUT !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (IDLE_OUT !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_idle: IDLE_OUT=%b after %0d cycles, expected 1", tag, IDLE_OUT, k);
    end
  endtask

  // Back-to-back simple-mode software triggers to advance TRIGGER_NUMBER.
  task automatic pump(input int n);
    MODE = 2'b00;
    for (int i = 0; i < n; i++) begin
      wait_idle("pump");
      SOFT_TRIG = 1'b1;
      tick(1);
      SOFT_TRIG = 1'b0;
    end
    wait_idle("pump_end");
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({TLU_TRIGGER, TLU_RESET, TRIGGER_NUMBER, ERR_CNT, IDLE_OUT} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: trig=%b rst=%b num=%0h err=%0d idle=%b, expected all 0",
               TLU_TRIGGER, TLU_RESET, TRIGGER_NUMBER, ERR_CNT, IDLE_OUT);
    end
    BUS_RST = 1'b0;
    tick(1);
    n_cmp++;
    if (IDLE_OUT !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle: IDLE_OUT=%b expected 1", IDLE_OUT);
    end
  endtask

  task automatic test_simple();
    int cnt = 0;
    ENABLE    = 1'b1;
    MODE      = 2'b00;
    TLU_BUSY  = 1'b1;
    SOFT_TRIG = 1'b1;
    tick(1);
    SOFT_TRIG = 1'b0;
    n_cmp++;
    if (TLU_TRIGGER !== 1'b1) begin
      n_bad++;
      $display("FAIL simple_start: TLU_TRIGGER=%b expected 1", TLU_TRIGGER);
    end
    while (TLU_TRIGGER === 1'b1 && cnt < 50) begin
      cnt++;
      tick(1);
    end
    n_cmp++;
    if (cnt != 4) begin
      n_bad++;
      $display("FAIL simple_width: high %0d cycles expected 4", cnt);
    end
    wait_idle("simple");
    TLU_BUSY = 1'b0;
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'h01) begin
      n_bad++;
      $display("FAIL simple_number: got %0h expected 1", TRIGGER_NUMBER);
    end
  endtask

  task automatic test_data_handshake();
    int lat = 0;
    logic [7:0] word = 8'h00;
    pump(8'hA5 - 1);
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'hA5) begin
      n_bad++;
      $display("FAIL pump_number: got %0h expected a5", TRIGGER_NUMBER);
    end
    MODE      = 2'b10;
    SOFT_TRIG = 1'b1;
    tick(1);
    SOFT_TRIG = 1'b0;
    tick(5);
    n_cmp++;
    if (TLU_TRIGGER !== 1'b1) begin
      n_bad++;
      $display("FAIL dhs_wait_busy: TLU_TRIGGER=%b expected 1", TLU_TRIGGER);
    end
    TLU_BUSY = 1'b1;
    while (TLU_TRIGGER === 1'b1 && lat < 20) begin
      tick(1);
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL dhs_busy_latency: %0d cycles expected 3", lat);
    end
    for (int k = 0; k < TB_BITS; k++) begin
      TLU_CLOCK = 1'b1;
      tick(3);
      word[k] = TLU_TRIGGER;
      TLU_CLOCK = 1'b0;
      tick(3);
    end
    n_cmp++;
    if (word !== 8'hA5) begin
      n_bad++;
      $display("FAIL dhs_word: got %0h expected a5", word);
    end
    n_cmp++;
    if (TLU_TRIGGER !== 1'b0 || IDLE_OUT !== 1'b0) begin
      n_bad++;
      $display("FAIL dhs_after_shift: trig=%b idle=%b expected 0 0", TLU_TRIGGER, IDLE_OUT);
    end
    TLU_BUSY = 1'b0;
    wait_idle("dhs");
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'hA6 || ERR_CNT !== 8'd0) begin
      n_bad++;
      $display("FAIL dhs_number: num=%0h err=%0d expected a6 0", TRIGGER_NUMBER, ERR_CNT);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    MODE      = 2'b01;
    SOFT_TRIG = 1'b1;
    tick(1);
    SOFT_TRIG = 1'b0;
    while (TLU_TRIGGER === 1'b1 && cnt < 1100) begin
      cnt++;
      tick(1);
    end
    n_cmp++;
    if (cnt != 1000) begin
      n_bad++;
      $display("FAIL timeout_width: high %0d cycles expected 1000", cnt);
    end
    n_cmp++;
    if (ERR_CNT !== 8'd1 || TRIGGER_NUMBER !== 8'hA6 || IDLE_OUT !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_state: err=%0d num=%0h idle=%b expected 1 a6 1",
               ERR_CNT, TRIGGER_NUMBER, IDLE_OUT);
    end
  endtask

  task automatic test_periodic();
    int starts = 0;
    int first = -1;
    int last = 0;
    int bad_gap = 0;
    logic prev;
    MODE   = 2'b00;
    PERIOD = 16'd100;
    prev   = TLU_TRIGGER;
    for (int t = 1; t <= 1005; t++) begin
      tick(1);
      if (TLU_TRIGGER === 1'b1 && prev === 1'b0) begin
        starts++;
        if (first < 0) first = t;
        else if (t - last != 100) bad_gap++;
        last = t;
      end
      prev = TLU_TRIGGER;
    end
    PERIOD = 16'd0;
    wait_idle("periodic");
    n_cmp++;
    if (starts != 10 || first != 101 || bad_gap != 0) begin
      n_bad++;
      $display("FAIL periodic: starts=%0d first=%0d bad_gaps=%0d expected 10 101 0",
               starts, first, bad_gap);
    end
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'hB0) begin
      n_bad++;
      $display("FAIL periodic_number: got %0h expected b0", TRIGGER_NUMBER);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    pump(8'hFF - 8'hB0);
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'hFF) begin
      n_bad++;
      $display("FAIL wrap_pre: got %0h expected ff", TRIGGER_NUMBER);
    end
    MODE      = 2'b01;
    SOFT_TRIG = 1'b1;
    tick(1);
    SOFT_TRIG = 1'b0;
    tick(2);
    TLU_BUSY = 1'b1;
    while (TLU_TRIGGER === 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    tick(2);
    TLU_BUSY = 1'b0;
    wait_idle("wrap");
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'h00 || ERR_CNT !== 8'd1) begin
      n_bad++;
      $display("FAIL wrap: num=%0h err=%0d expected 0 1", TRIGGER_NUMBER, ERR_CNT);
    end
  endtask

  task automatic test_clear_holdoff();
    MODE      = 2'b00;
    SOFT_TRIG = 1'b1;
    tick(1);
    SOFT_TRIG = 1'b0;
    tick(4);
    n_cmp++;
    if (TLU_TRIGGER !== 1'b0 || IDLE_OUT !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_holdoff_pre: trig=%b idle=%b expected 0 0", TLU_TRIGGER, IDLE_OUT);
    end
    CLEAR_CNT = 1'b1;
    tick(1);
    CLEAR_CNT = 1'b0;
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'h00 || ERR_CNT !== 8'd0 || TLU_RESET !== 1'b1 || IDLE_OUT !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_holdoff: num=%0h err=%0d tlu_reset=%b idle=%b expected 0 0 1 1",
               TRIGGER_NUMBER, ERR_CNT, TLU_RESET, IDLE_OUT);
    end
    tick(1);
    n_cmp++;
    if (TLU_RESET !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_reset_width: TLU_RESET=%b expected 0", TLU_RESET);
    end
    pump(1);
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'h01) begin
      n_bad++;
      $display("FAIL clear_after: got %0h expected 1", TRIGGER_NUMBER);
    end
  endtask

  task automatic test_back_to_back();
    int s1 = -1;
    int s2 = -1;
    logic prev;
    MODE   = 2'b00;
    PERIOD = 16'd2;
    prev   = TLU_TRIGGER;
    for (int t = 1; t <= 30; t++) begin
      tick(1);
      if (TLU_TRIGGER === 1'b1 && prev === 1'b0) begin
        if (s1 < 0) s1 = t;
        else if (s2 < 0) s2 = t;
      end
      prev = TLU_TRIGGER;
    end
    ENABLE = 1'b0;
    PERIOD = 16'd0;
    wait_idle("b2b");
    tick(3);
    n_cmp++;
    if (s1 != 3 || s2 != 9) begin
      n_bad++;
      $display("FAIL b2b_starts: first=%0d second=%0d expected 3 9", s1, s2);
    end
    n_cmp++;
    if (TRIGGER_NUMBER !== 8'h06 || TLU_TRIGGER !== 1'b0 || IDLE_OUT !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain: num=%0h trig=%b idle=%b expected 6 0 1",
               TRIGGER_NUMBER, TLU_TRIGGER, IDLE_OUT);
    end
  endtask

  task automatic test_enable_off();
    int hi = 0;
    ENABLE    = 1'b0;
    SOFT_TRIG = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick(1);
      if (TLU_TRIGGER === 1'b1) hi++;
    end
    SOFT_TRIG = 1'b0;
    n_cmp++;
    if (hi != 0 || TRIGGER_NUMBER !== 8'h06) begin
      n_bad++;
      $display("FAIL enable_off: high cycles=%0d num=%0h expected 0 6", hi, TRIGGER_NUMBER);
    end
  endtask

`ifdef TLU_EMU_VETO_EN
  task automatic test_veto();
    int hi = 0;
    ENABLE = 1'b1;
    VETO   = 1'b1;
    MODE   = 2'b00;
    PERIOD = 16'd10;
    for (int t = 0; t < 35; t++) begin
      tick(1);
      if (TLU_TRIGGER === 1'b1) hi++;
    end
    PERIOD = 16'd0;
    tick(2);
    VETO = 1'b0;
    n_cmp++;
    if (hi != 0 || VETO_CNT !== 16'd3) begin
      n_bad++;
      $display("FAIL veto: high cycles=%0d veto_cnt=%0d expected 0 3", hi, VETO_CNT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_simple();
    test_data_handshake();
    test_timeout();
    test_periodic();
    test_wrap();
    test_clear_holdoff();
    test_back_to_back();
    test_enable_off();
`ifdef TLU_EMU_VETO_EN
    test_veto();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
